// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: widths, op encodings and the
// per-requester operand bundle.
package shift_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;
    localparam int CNTR_W = 8;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRL = 2'b11
    } shift_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  amt;
        shift_op_e         op;
    } shift_req_t;

    function automatic logic [CNTR_W-1:0] sat_inc(input logic [CNTR_W-1:0] v);
        return (v == {CNTR_W{1'b1}}) ? v : v + CNTR_W'(1);
    endfunction

endpackage

// File: rtl/shift_arb_shifter.sv
// Combinational 16-bit barrel shifter: rotate or logical shift, zero fill.
module shift_arb_shifter
    import shift_pkg::*;
(
    input  shift_req_t        req,
    output logic [DATA_W-1:0] result
);

    logic [CNT_W:0]    inv_amt;
    logic [DATA_W-1:0] rol_val;
    logic [DATA_W-1:0] ror_val;

    // A zero amount gives inv_amt = 16, which shifts the wrap term out entirely.
    assign inv_amt = (CNT_W+1)'(DATA_W) - {1'b0, req.amt};
    assign rol_val = (req.data << req.amt) | (req.data >> inv_amt);
    assign ror_val = (req.data >> req.amt) | (req.data << inv_amt);

    always_comb begin
        result = '0;
        case (req.op)
            OP_ROL:  result = rol_val;
            OP_SLL:  result = req.data << req.amt;
            OP_ROR:  result = ror_val;
            OP_SRL:  result = req.data >> req.amt;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/shift_arb.sv
// Two-requester round-robin arbiter in front of one shared shifter, with a
// single registered result slot and saturating per-requester accept counters.
module shift_arb
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_in,
    input  logic [CNT_W-1:0]  req0_cnt,
    input  logic [1:0]        req0_op,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_in,
    input  logic [CNT_W-1:0]  req1_cnt,
    input  logic [1:0]        req1_op,
    output logic              req1_ready,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    input  logic              resp_ready,
    output logic [CNTR_W-1:0] cnt0,
    output logic [CNTR_W-1:0] cnt1
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]        state_reg;
    logic              last_reg;
    logic              id_reg;
    logic [DATA_W-1:0] data_reg;

    logic              slot_free;
    logic              gnt0;
    logic              gnt1;
    logic [1:0]        gnt_vec;
    shift_req_t        sel_req;
    logic [DATA_W-1:0] shift_out;

    // Slot frees either when empty or when the held result leaves this cycle.
    assign slot_free = !rst && ((state_reg == EMPTY) || resp_ready);
    assign gnt0      = slot_free && req0_valid && (!req1_valid || last_reg);
    assign gnt1      = slot_free && req1_valid && (!req0_valid || !last_reg);
    assign gnt_vec   = {gnt1, gnt0};

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        sel_req.data = req0_in;
        sel_req.amt  = req0_cnt;
        sel_req.op   = shift_op_e'(req0_op);
        if (gnt1) begin
            sel_req.data = req1_in;
            sel_req.amt  = req1_cnt;
            sel_req.op   = shift_op_e'(req1_op);
        end
    end

    shift_arb_shifter u_shifter (
        .req    (sel_req),
        .result (shift_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
            last_reg  <= 1'b1;
            id_reg    <= 1'b0;
            data_reg  <= '0;
        end else if (gnt0 || gnt1) begin
            state_reg <= FULL;
            last_reg  <= gnt1;
            id_reg    <= gnt1;
            data_reg  <= shift_out;
        end else if (resp_ready) begin
            state_reg <= EMPTY;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
            logic [CNTR_W-1:0] cnt_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (gnt_vec[gi]) begin
                    cnt_reg <= sat_inc(cnt_reg);
                end
            end
        end
    endgenerate

    assign resp_valid = (state_reg == FULL);
    assign resp_id    = id_reg;
    assign resp_data  = data_reg;
    assign cnt0       = gen_cnt[0].cnt_reg;
    assign cnt1       = gen_cnt[1].cnt_reg;

endmodule

// File: tb/tb_shift_arb.sv
// Directed bench for shift_arb: a table of single-requester shifts plus
// hand-written contention, back-pressure, saturation and async-reset sequences.
module tb_shift_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_in, req1_in;
    logic [3:0]  req0_cnt, req1_cnt;
    logic [1:0]  req0_op, req1_op;
    logic        req0_ready, req1_ready;
    logic        resp_valid, resp_id, resp_ready;
    logic [15:0] resp_data;
    logic [7:0]  cnt0, cnt1;

    int total = 0;
    int bad   = 0;
    int e0    = 0;
    int e1    = 0;

    typedef struct {
        logic        id;
        logic [15:0] din;
        logic [3:0]  amt;
        logic [1:0]  op;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    shift_arb dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_in    (req0_in),
        .req0_cnt   (req0_cnt),
        .req0_op    (req0_op),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_in    (req1_in),
        .req1_cnt   (req1_cnt),
        .req1_op    (req1_op),
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    initial begin
        // ops: ROL=0 SLL=1 ROR=2 SRL=3
        vecs[0]  = '{1'b0, 16'h8001, 4'd1,  2'd0, 16'h0003};
        vecs[1]  = '{1'b0, 16'hA5A5, 4'd0,  2'd0, 16'hA5A5};
        vecs[2]  = '{1'b1, 16'hA5A5, 4'd0,  2'd1, 16'hA5A5};
        vecs[3]  = '{1'b0, 16'hA5A5, 4'd0,  2'd2, 16'hA5A5};
        vecs[4]  = '{1'b1, 16'hA5A5, 4'd0,  2'd3, 16'hA5A5};
        vecs[5]  = '{1'b1, 16'h1234, 4'd4,  2'd3, 16'h0123};
        vecs[6]  = '{1'b0, 16'h1234, 4'd4,  2'd1, 16'h2340};
        vecs[7]  = '{1'b1, 16'h1234, 4'd4,  2'd2, 16'h4123};
        vecs[8]  = '{1'b0, 16'h1234, 4'd4,  2'd0, 16'h2341};
        vecs[9]  = '{1'b1, 16'h8000, 4'd15, 2'd3, 16'h0001};
        vecs[10] = '{1'b0, 16'h0001, 4'd15, 2'd1, 16'h8000};
        vecs[11] = '{1'b1, 16'h0001, 4'd1,  2'd2, 16'h8000};
        vecs[12] = '{1'b0, 16'hF00F, 4'd8,  2'd2, 16'h0FF0};
        vecs[13] = '{1'b1, 16'h8001, 4'd15, 2'd0, 16'hC000};

        rst = 1'b1;
        req0_valid = 1'b1; req0_in = 16'h1111; req0_cnt = 4'd1; req0_op = 2'd1;
        req1_valid = 1'b1; req1_in = 16'h2222; req1_cnt = 4'd1; req1_op = 2'd1;
        resp_ready = 1'b1;

        // Reset state, readies suppressed while rst is high.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_data", resp_data, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);

        // Contention right after reset: req0 first, then req1.
        @(negedge clk);
        rst = 1'b0;
        req0_in = 16'h1234; req0_cnt = 4'd4; req0_op = 2'd1;
        req1_in = 16'h1234; req1_cnt = 4'd4; req1_op = 2'd2;
        #1;
        chk("rr1_ready0", req0_ready, 1);
        chk("rr1_ready1", req1_ready, 0);
        @(posedge clk); #1;
        chk("rr1_valid", resp_valid, 1);
        chk("rr1_id", resp_id, 0);
        chk("rr1_data", resp_data, 16'h2340);
        chk("rr2_ready0", req0_ready, 0);
        chk("rr2_ready1", req1_ready, 1);
        @(posedge clk); #1;
        chk("rr2_valid", resp_valid, 1);
        chk("rr2_id", resp_id, 1);
        chk("rr2_data", resp_data, 16'h4123);
        chk("rr_cnt0", cnt0, 1);
        chk("rr_cnt1", cnt1, 1);
        e0 = 1; e1 = 1;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain_valid", resp_valid, 0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            req0_valid = (vecs[i].id == 1'b0);
            req1_valid = (vecs[i].id == 1'b1);
            req0_in = vecs[i].din; req0_cnt = vecs[i].amt; req0_op = vecs[i].op;
            req1_in = vecs[i].din; req1_cnt = vecs[i].amt; req1_op = vecs[i].op;
            resp_ready = 1'b1;
            #1;
            chk($sformatf("v%0d_ready0", i), req0_ready, (vecs[i].id == 1'b0));
            chk($sformatf("v%0d_ready1", i), req1_ready, (vecs[i].id == 1'b1));
            @(posedge clk); #1;
            if (vecs[i].id) e1++; else e0++;
            chk($sformatf("v%0d_valid", i), resp_valid, 1);
            chk($sformatf("v%0d_id", i), resp_id, vecs[i].id);
            chk($sformatf("v%0d_data", i), resp_data, vecs[i].exp);
        end
        chk("tbl_cnt0", cnt0, e0);
        chk("tbl_cnt1", cnt1, e1);

        // Back-pressure: held result stays put, queued req0 accepted on release.
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        req1_valid = 1'b1; req1_in = 16'h1234; req1_cnt = 4'd4; req1_op = 2'd3;
        resp_ready = 1'b0;
        #1;
        chk("bp_accept1", req1_ready, 1);
        @(negedge clk);
        e1++;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_in = 16'h8001; req0_cnt = 4'd1; req0_op = 2'd0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_ready0", c), req0_ready, 0);
            chk($sformatf("bp%0d_ready1", c), req1_ready, 0);
            chk($sformatf("bp%0d_valid", c), resp_valid, 1);
            chk($sformatf("bp%0d_id", c), resp_id, 1);
            chk($sformatf("bp%0d_data", c), resp_data, 16'h0123);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_rel_ready0", req0_ready, 1);
        @(posedge clk); #1;
        e0++;
        chk("bp_rel_id", resp_id, 0);
        chk("bp_rel_data", resp_data, 16'h0003);
        chk("bp_cnt1", cnt1, e1);

        // Streaming req0 until the counter saturates.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            req0_in = i[15:0]; req0_cnt = 4'd0; req0_op = 2'd1;
            #1;
            chk($sformatf("st%0d_ready0", i), req0_ready, 1);
            @(posedge clk); #1;
            chk($sformatf("st%0d_data", i), {resp_valid, resp_data}, {1'b1, i[15:0]});
        end
        chk("sat_cnt0", cnt0, 8'hFF);
        chk("sat_cnt1", cnt1, e1);

        // Asynchronous reset while FULL, away from any clock edge.
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b1; resp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", resp_valid, 0);
        chk("arst_id", resp_id, 0);
        chk("arst_data", resp_data, 0);
        chk("arst_cnt0", cnt0, 0);
        chk("arst_cnt1", cnt1, 0);
        chk("arst_ready1", req1_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1;
        #1;
        chk("arst_ptr_ready0", req0_ready, 1);
        chk("arst_ptr_ready1", req1_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_arb.md
SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: req0_valid  in  1  requester 0 has a shift operation.
REQ-004 SHALL have ports: req0_in  in  16  / req0_cnt  in  4  / req0_op  in  2  (requester 0 operand, count, op).
REQ-005 SHALL have ports: req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 SHALL have ports: req1_valid, req1_in, req1_cnt, req1_op, req1_ready, same widths and meanings for requester 1.
REQ-007 SHALL have ports: resp_valid  out  1 / resp_id  out  1 / resp_data  out  16  (registered result channel).
REQ-008 SHALL have ports: resp_ready  in  1  consumer takes the result when high with resp_valid.
REQ-009 SHALL have ports: cnt0  out  8 / cnt1  out  8  (saturating count of accepted operations per requester).

Function
REQ-010 SHALL use op encoding ROL=00, SLL=01, ROR=10, SRL=11, shift amount 0..15, with zero fill for SLL/SRL.
REQ-011 SHALL use a two-state FSM: EMPTY (no held result) and FULL (result held, resp_valid=1).
REQ-012 SHALL define accept as: slot free = EMPTY or (FULL and resp_ready); a grant occurs only when the slot is free.
REQ-013 SHALL grant, when exactly one requester is valid and the slot is free, that requester.
REQ-014 SHALL grant, when both are valid and the slot is free, the requester not granted last (round-robin), then update the last-grant pointer to the winner.
REQ-015 SHALL reset the last-grant pointer to 1, so requester 0 wins the first contention.
REQ-016 SHALL assert reqN_ready combinationally only for the granted requester, and never for both requesters in one cycle.
REQ-017 SHALL, on grant in cycle N, register the shifter output for the winner's operands and the winner's id, so resp_valid=1 in cycle N+1 (latency 1).
REQ-018 SHALL, on FULL with resp_ready=1 and a new grant, replace the result in the same edge and stay FULL (back-to-back throughput 1/cycle).
REQ-019 SHALL, on FULL with resp_ready=1 and no grant, go to EMPTY with resp_valid=0 next cycle.
REQ-020 SHALL, on FULL with resp_ready=0, hold resp_data and resp_id stable and keep req0_ready=req1_ready=0.
REQ-021 SHALL leave the pointer and counters unchanged when a requester drops valid without a grant.
REQ-022 SHALL increment cntN by 1 on each accept for requester N, saturating at 8'hFF.
REQ-023 SHALL drive resp_data, resp_id and the counters from registers only (no combinational path from inputs).

Reset
REQ-024 SHALL, on rst=1 at any time including mid-transfer, immediately force EMPTY, resp_valid=0, resp_id=0, resp_data=16'h0000, cnt0=cnt1=0, pointer=1; a held result is discarded.
REQ-025 SHALL hold req0_ready=req1_ready=0 while rst=1.

Structure
REQ-026 SHALL take the op encodings, data width 16 and count width 4 from a shared package, shift_pkg.
REQ-027 SHALL instantiate exactly one existing shifter sub-module, shared between requesters via a 2:1 operand mux driven by the grant.

Verification
REQ-028 SHALL be covered by: req0 only, in=16'h8001, cnt=1, op=ROL -> resp_valid next cycle, id=0, data=16'h0003, cnt0=1.
REQ-029 SHALL be covered by: both valid after reset, req0 SLL 4 of 16'h1234, req1 ROR 4 of 16'h1234, resp_ready=1 -> first response id=0 data=16'h2340, next cycle id=1 data=16'h4123.
REQ-030 SHALL be covered by: resp_ready=0 for 3 cycles after a req1 SRL 4 of 16'h1234 -> resp_data=16'h0123 held, both readies 0; when resp_ready=1 the queued req0 is accepted in the same cycle.
REQ-031 SHALL be covered by: req0 streaming 300 accepts with resp_ready=1 -> one response per cycle, cnt0 saturates at 8'hFF.
REQ-032 SHALL be covered by: rst pulsed asynchronously while FULL -> resp_valid falls without a clock edge and the counters read 0.
REQ-033 SHALL be covered by: cnt=0 with each of the four ops on 16'hA5A5 -> data=16'hA5A5 in all cases.
